output_deskew: RTL and testbench
================================

OUTPUT_DESKEW -- requirements
Module: output_deskew

Interface
REQ-001 Parameter NumLanes, default 4, number of skewed lanes (>=2).
REQ-002 Parameter DataWidth, default 8, bits per lane.
REQ-003 Parameter FifoDepth, default 4, aligned-row FIFO entries (power of 2, >=2).
REQ-004 clk_i  input  1  clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 clear_i  input  1  synchronous flush.
REQ-007 in_valid_i  input  1  row start; qualifies lane 0 this cycle.
REQ-008 in_data_i  input  NumLanes*DataWidth  skewed lanes; lane k at bits [k*DataWidth +: DataWidth].
REQ-009 out_valid_o  output  1  aligned row available.
REQ-010 out_ready_i  input  1  consumer accepts row.
REQ-011 out_data_o  output  NumLanes*DataWidth  aligned row, same lane packing as in_data_i.
REQ-012 fifo_count_o  output  $clog2(FifoDepth)+1  rows held.
REQ-013 overflow_o  output  1  sticky: an aligned row was dropped.

Function
REQ-014 Skew contract: for a row started by in_valid_i=1 in cycle t, lane k data SHALL be sampled in cycle t+k; no per-lane valid exists.
REQ-015 Lane k SHALL be delayed NumLanes-1-k cycles, so lane NumLanes-1 is undelayed.
REQ-016 in_valid_i SHALL be delayed NumLanes-1 cycles; in cycle t+NumLanes-1 the aligned row SHALL be pushed into the FIFO at that cycle's clock edge.
REQ-017 With an empty FIFO, out_valid_o SHALL assert in cycle t+NumLanes; latency NumLanes cycles.
REQ-018 in_valid_i may assert every cycle; consecutive rows SHALL stay distinct and in order.
REQ-019 FIFO SHALL be first-word-fall-through: out_data_o shows the head row whenever out_valid_o=1.
REQ-020 out_valid_o SHALL equal (fifo_count_o != 0).
REQ-021 A pop SHALL occur on the clock edge when out_valid_o & out_ready_i.
REQ-022 out_valid_o and out_data_o SHALL hold stable while out_ready_i=0.
REQ-023 Push with the FIFO not full SHALL store the row; fifo_count_o SHALL increment unless a pop occurs on the same edge.
REQ-024 Push with the FIFO full and a pop on the same edge SHALL succeed; count stays FifoDepth; no overflow.
REQ-025 Push with the FIFO full and no pop SHALL drop the new row; FIFO contents remain unchanged; overflow_o is set.
REQ-026 overflow_o SHALL remain set until clear_i or reset.
REQ-027 Read/write pointers SHALL wrap modulo FifoDepth with no lost or duplicated rows.
REQ-028 clear_i=1 SHALL, at the next edge, empty the FIFO, zero the delayed-valid pipeline (abandoning in-flight rows), and clear overflow_o.
REQ-029 clear_i SHALL take priority over a simultaneous push and pop.
REQ-030 Lane data delay registers need no flush; out_data_o content is only meaningful while out_valid_o=1.
REQ-031 out_ready_i SHALL have no combinational effect on any output other than by advancing state.

Reset
REQ-032 rst_ni=0 SHALL asynchronously zero all lane delay registers, the delayed-valid pipeline, FIFO pointers, the count and the overflow flag.
REQ-033 During reset: out_valid_o=0, fifo_count_o=0, overflow_o=0, out_data_o=0.
REQ-034 Rows in flight when reset asserts SHALL be lost; the first row started after release SHALL emerge with normal latency.

Verification (NumLanes=4, DataWidth=8, FifoDepth=4)
REQ-035 Single row with out_ready_i=1: in_valid_i at c0, lanes 0x11@c0, 0x22@c1, 0x33@c2, 0x44@c3 -> out_valid_o=1 only in c4, out_data_o=0x44332211, fifo_count_o back to 0 in c5.
REQ-036 Streaming: 6 back-to-back rows with row n lane k = {n[3:0],k[3:0]} and ready=1 -> out_valid_o high c4..c9; rows emerge in order with correct packing; fifo_count_o never exceeds 1.
REQ-037 Overflow: ready=0, 5 back-to-back rows -> fifo_count_o=4; overflow_o=1 from c8 onward; then ready=1 -> rows 0-3 drain in order; row 4 is never seen.
REQ-038 Full plus simultaneous pop: FIFO full, ready=1 on the same edge as the 5th push -> overflow_o stays 0; all 5 rows delivered in order.
REQ-039 Reset mid-row: rst_ni low at c2 of a row, released at c5; new row at c7 -> no output from the first row; second row emerges at c11.
REQ-040 Clear: FIFO holding 2 rows, overflow_o=1, plus one row in flight, then clear_i for one cycle -> count=0, out_valid_o=0, overflow_o=0 next cycle; the in-flight row never appears.

Source files
------------

// File: rtl/output_deskew.sv
// Realigns lanes that arrive with a staircase skew (lane k sampled k cycles after
// the row start) and buffers the aligned rows in a first-word-fall-through FIFO.
module output_deskew #(
    parameter int NumLanes  = 4,
    parameter int DataWidth = 8,
    parameter int FifoDepth = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              in_valid_i,
    input  logic [NumLanes*DataWidth-1:0]     in_data_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [NumLanes*DataWidth-1:0]     out_data_o,
    output logic [$clog2(FifoDepth):0]        fifo_count_o,
    output logic                              overflow_o
);

    localparam int RowW = NumLanes * DataWidth;
    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);

    logic [RowW-1:0]      row_p0;
    logic [NumLanes-2:0]  vld_q;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 push_ok;
    logic                 drop;
    logic [RowW-1:0]      mem [FifoDepth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [CntW-1:0]      count;
    logic                 overflow;

    // Stage p0: lane k waits NumLanes-1-k cycles so every lane lines up with the last one.
    for (genvar k = 0; k < NumLanes; k++) begin : g_lane
        localparam int Dly = NumLanes - 1 - k;
        if (Dly == 0) begin : g_pass
            assign row_p0[k*DataWidth +: DataWidth] = in_data_i[k*DataWidth +: DataWidth];
        end else begin : g_dly
            logic [DataWidth-1:0] dly_q [Dly];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int j = 0; j < Dly; j++) dly_q[j] <= '0;
                end else begin
                    dly_q[0] <= in_data_i[k*DataWidth +: DataWidth];
                    for (int j = 1; j < Dly; j++) dly_q[j] <= dly_q[j-1];
                end
            end
            assign row_p0[k*DataWidth +: DataWidth] = dly_q[Dly-1];
        end
    end

    // Row-start marker travels with the slowest lane; clear abandons rows in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else if (clear_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid_i;
            for (int i = 1; i < NumLanes - 1; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    assign push    = vld_q[NumLanes-2];
    assign full    = (count == FullCnt);
    assign pop     = out_valid_o & out_ready_i;
    // A full FIFO still accepts a row when the head leaves on the same edge.
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    // Stage p1: aligned-row FIFO, control state only is reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)     rd_ptr <= rd_ptr + PtrW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) mem[wr_ptr] <= row_p0;
    end

    assign out_valid_o  = (count != '0);
    assign out_data_o   = out_valid_o ? mem[rd_ptr] : '0;
    assign fifo_count_o = count;
    assign overflow_o   = overflow;

endmodule

// File: tb/tb_output_deskew.sv
// Scoreboard bench for output_deskew: directed rows are queued at issue time and
// a negedge monitor compares every accepted output row against the queue head.
module tb_output_deskew;

    localparam int NL = 4;
    localparam int DW = 8;
    localparam int FD = 4;

    logic              clk;
    logic              rst_ni;
    logic              clear;
    logic              in_valid;
    logic [NL*DW-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [NL*DW-1:0]  out_data;
    logic [2:0]        fifo_count;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] hist_row [NL];
    bit          hist_v   [NL];

    output_deskew #(.NumLanes(NL), .DataWidth(DW), .FifoDepth(FD)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .clear_i      (clear),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .fifo_count_o (fifo_count),
        .overflow_o   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle: lane k carries the row started k cycles ago.
    task automatic cycle(input bit v, input logic [31:0] row, input bit keep);
        for (int k = NL - 1; k > 0; k--) begin
            hist_row[k] = hist_row[k-1];
            hist_v[k]   = hist_v[k-1];
        end
        hist_row[0] = row;
        hist_v[0]   = v;
        for (int k = 0; k < NL; k++)
            in_data[k*DW +: DW] = hist_v[k] ? hist_row[k][k*DW +: DW] : 8'hA5;
        in_valid = v;
        if (v && keep) exp_q.push_back(row);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted row must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_ni && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_row", out_data, 32'hDEADBEEF);
            end else begin
                chk("row_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    logic [31:0] stream_rows [6];
    logic [31:0] ovf_rows    [5];
    logic [31:0] pop_rows    [5];
    int maxcnt;

    initial begin
        stream_rows = '{32'h03020100, 32'h13121110, 32'h23222120,
                        32'h33323130, 32'h43424140, 32'h53525150};
        ovf_rows    = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0,
                        32'hD3D2D1D0, 32'hE3E2E1E0};
        pop_rows    = '{32'h0F0E0D0C, 32'h1F1E1D1C, 32'h2F2E2D2C,
                        32'h3F3E3D3C, 32'h4F4E4D4C};
        for (int k = 0; k < NL; k++) begin
            hist_row[k] = '0;
            hist_v[k]   = 1'b0;
        end
        rst_ni    = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hFFFFFFFF;
        out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_count", {29'b0, fifo_count}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        in_valid = 1'b0;
        rst_ni   = 1'b1;
        repeat (2) cycle(0, '0, 0);

        // Single row, latency NumLanes.
        out_ready = 1'b1;
        cycle(1, 32'h44332211, 1);
        chk("single_c1_valid", {31'b0, out_valid}, 32'd0);
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        chk("single_c3_valid", {31'b0, out_valid}, 32'd0);
        cycle(0, '0, 0);
        chk("single_c4_valid", {31'b0, out_valid}, 32'd1);
        chk("single_c4_count", {29'b0, fifo_count}, 32'd1);
        cycle(0, '0, 0);
        chk("single_c5_valid", {31'b0, out_valid}, 32'd0);
        chk("single_c5_count", {29'b0, fifo_count}, 32'd0);
        repeat (2) cycle(0, '0, 0);

        // Back-to-back streaming.
        maxcnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(i < 6, (i < 6) ? stream_rows[i] : 32'h0, 1);
            chk("stream_valid", {31'b0, out_valid}, {31'b0, (i + 1 >= 4 && i + 1 <= 9)});
            if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
        end
        chk("stream_maxcnt", maxcnt, 32'd1);

        // Overflow with consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(i < 5, (i < 5) ? ovf_rows[i] : 32'h0, i < 4);
            if (i == 6) begin
                chk("ovf_c7_count", {29'b0, fifo_count}, 32'd4);
                chk("ovf_c7_ovf", {31'b0, overflow}, 32'd0);
            end
        end
        chk("ovf_c8_count", {29'b0, fifo_count}, 32'd4);
        chk("ovf_c8_ovf", {31'b0, overflow}, 32'd1);
        chk("ovf_hold_data", out_data, 32'hA3A2A1A0);
        out_ready = 1'b1;
        repeat (6) cycle(0, '0, 0);
        chk("ovf_drain_count", {29'b0, fifo_count}, 32'd0);
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);
        clear = 1'b1;
        cycle(0, '0, 0);
        clear = 1'b0;
        chk("ovf_cleared", {31'b0, overflow}, 32'd0);

        // Full FIFO with pop on the same edge as the extra push.
        for (int i = 0; i < 8; i++) begin
            out_ready = (i >= 7);
            cycle(i < 5, (i < 5) ? pop_rows[i] : 32'h0, 1);
        end
        chk("fullpop_count", {29'b0, fifo_count}, 32'd4);
        chk("fullpop_ovf", {31'b0, overflow}, 32'd0);
        repeat (6) cycle(0, '0, 0);
        chk("fullpop_drained", {29'b0, fifo_count}, 32'd0);

        // Reset in the middle of a row.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rst_ni = !(i >= 2 && i < 5);
            cycle(i == 0 || i == 7, (i == 0) ? 32'h77665544 : 32'hBBAA9988, i == 7);
            chk("rstmid_valid", {31'b0, out_valid}, {31'b0, (i + 1 == 11)});
        end
        rst_ni = 1'b1;
        chk("rstmid_count", {29'b0, fifo_count}, 32'd0);
        repeat (2) cycle(0, '0, 0);

        // Clear with two rows held, overflow set and one row in flight.
        for (int i = 0; i < 10; i++) begin
            out_ready = (i == 8 || i == 9);
            cycle(i < 5 || i == 9, (i < 5) ? ovf_rows[i] : 32'h5A5A5A5A, i < 4);
        end
        out_ready = 1'b0;
        chk("clr_pre_count", {29'b0, fifo_count}, 32'd2);
        chk("clr_pre_ovf", {31'b0, overflow}, 32'd1);
        clear = 1'b1;
        exp_q.delete();
        cycle(0, '0, 0);
        clear = 1'b0;
        chk("clr_count", {29'b0, fifo_count}, 32'd0);
        chk("clr_valid", {31'b0, out_valid}, 32'd0);
        chk("clr_ovf", {31'b0, overflow}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(0, '0, 0);
            chk("clr_inflight_gone", {31'b0, out_valid}, 32'd0);
        end

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
